hidden_forward: RTL and testbench

Forward-pass stage for the single-hidden-neuron network, sitting directly upstream of the hidden-layer backprop stage. On a start pulse it captures the 4-bit input pattern and current weights, then accumulates the weighted hidden sum over four cycles. It scales the hidden sum by the output weight and presents `hidden_val_o` and `final_o`, with a one-cycle `done_o` pulse. The backprop stage consumes those two results and its enable is driven from `done_o`.

---
 rtl/hidden_forward.sv | 118 +++++++++++
 tb/tb_hidden_forward.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hidden_forward.sv
// Forward pass for the single-hidden-neuron network: gated weight accumulation over four
// cycles, optional saturating bias (HIDDEN_FWD_BIAS_EN), then scaling by the output weight.
module hidden_forward (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        zero_weight_reset_i,
  input  logic        start_i,
  input  logic [3:0]  x_i,
  input  logic [7:0]  w0_i,
  input  logic [7:0]  w1_i,
  input  logic [7:0]  w2_i,
  input  logic [7:0]  w3_i,
  input  logic [7:0]  w_out_i,
  input  logic [7:0]  bias_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [9:0]  hidden_val_o,
  output logic [18:0] final_o
);

  typedef enum logic [1:0] {StIdle, StAcc, StAct, StMul} state_e;

  state_e            state_q;
  logic [1:0]        k_q;
  logic [3:0]        x_q;
  logic [3:0][7:0]   w_q;
  logic [7:0]        w_out_q;
  logic [9:0]        acc_q;
  logic [9:0]        hidden_val_q;
  logic [18:0]       final_q;
  logic              done_q;
  logic              busy_q;

  logic [7:0]        acc_term;
  logic [9:0]        acc_d;
  logic [9:0]        hidden_val_d;
  logic [17:0]       prod_d;

  assign acc_term = x_q[k_q] ? w_q[k_q] : 8'd0;
  assign acc_d    = acc_q + {2'b00, acc_term};
  assign prod_d   = {8'd0, hidden_val_q} * {10'd0, w_out_q};

`ifdef HIDDEN_FWD_BIAS_EN
  logic [7:0]  bias_q;
  logic [10:0] biased_sum;

  // 11-bit sum so the carry out can drive saturation to 1023.
  assign biased_sum   = {1'b0, acc_q} + {3'b000, bias_q};
  assign hidden_val_d = biased_sum[10] ? 10'h3ff : biased_sum[9:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i || zero_weight_reset_i) begin
      bias_q <= 8'd0;
    end else if (state_q == StIdle && start_i) begin
      bias_q <= bias_i;
    end
  end
`else
  logic unused_bias;

  assign unused_bias  = ^bias_i;
  assign hidden_val_d = acc_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i || zero_weight_reset_i) begin
      state_q      <= StIdle;
      k_q          <= 2'd0;
      x_q          <= 4'd0;
      w_q          <= '0;
      w_out_q      <= 8'd0;
      acc_q        <= 10'd0;
      hidden_val_q <= 10'd0;
      final_q      <= 19'd0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            x_q     <= x_i;
            w_q     <= {w3_i, w2_i, w1_i, w0_i};
            w_out_q <= w_out_i;
            acc_q   <= 10'd0;
            k_q     <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= StAcc;
          end
        end
        StAcc: begin
          acc_q <= acc_d;
          k_q   <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_q <= StAct;
          end
        end
        StAct: begin
          hidden_val_q <= hidden_val_d;
          state_q      <= StMul;
        end
        StMul: begin
          final_q <= {1'b0, prod_d};
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign hidden_val_o = hidden_val_q;
  assign final_o      = final_q;

endmodule

// File: tb/tb_hidden_forward.sv
// Bench for hidden_forward: pass-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with resets.
module tb_hidden_forward;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        zwr;
  logic        start;
  logic [3:0]  x;
  logic [7:0]  w0, w1, w2, w3, w_out, bias;
  logic        busy, done;
  logic [9:0]  hidden_val;
  logic [18:0] final_val;

  int checks = 0;
  int errors = 0;

  // Reference model state: a pass is described by cycles elapsed since its accept.
  int          m_phase = 0;
  int          m_x, m_wout, m_bias;
  int          m_w[4];
  int          m_hidden = 0, m_final = 0;
  bit          m_done = 0, m_busy = 0;

  always #5 clk = ~clk;

  hidden_forward dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .zero_weight_reset_i (zwr),
    .start_i             (start),
    .x_i                 (x),
    .w0_i                (w0),
    .w1_i                (w1),
    .w2_i                (w2),
    .w3_i                (w3),
    .w_out_i             (w_out),
    .bias_i              (bias),
    .busy_o              (busy),
    .done_o              (done),
    .hidden_val_o        (hidden_val),
    .final_o             (final_val)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int weighted_sum();
    int s = 0;
    for (int k = 0; k < 4; k++) if (m_x[k]) s += m_w[k];
`ifdef HIDDEN_FWD_BIAS_EN
    s += m_bias;
    if (s > 1023) s = 1023;
`endif
    return s;
  endfunction

  task automatic model_edge();
    if (!rst_n || zwr) begin
      m_phase = 0; m_hidden = 0; m_final = 0; m_done = 0; m_busy = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_x = int'(x); m_wout = int'(w_out); m_bias = int'(bias);
          m_w[0] = int'(w0); m_w[1] = int'(w1); m_w[2] = int'(w2); m_w[3] = int'(w3);
          m_phase = 1;
          m_busy  = 1;
        end
      end else begin
        m_phase++;
        if (m_phase == 6) m_hidden = weighted_sum();
        if (m_phase == 7) begin
          m_final = m_hidden * m_wout;
          m_done  = 1;
          m_busy  = 0;
          m_phase = 0;
        end
      end
    end
  endtask

  // One clock: DUT and model see the same inputs, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("hidden_val", 32'(hidden_val), 32'(m_hidden));
    chk("final", 32'(final_val), 32'(m_final));
  endtask

  task automatic set_in(input logic [3:0] xv, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input logic [7:0] wo,
                        input logic [7:0] bv);
    x = xv; w0 = a; w1 = b; w2 = c; w3 = d; w_out = wo; bias = bv;
  endtask

  // Pulse start once, then watch 10 cycles for latency, busy length and single done.
  task automatic run_pass(input string name, input int exp_h, input int exp_f);
    int done_at = -1, done_cnt = 0, busy_cnt = 0;
    start = 1'b1;
    step();
    busy_cnt += int'(busy);
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      busy_cnt += int'(busy);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    chk({name, "_latency"}, 32'(done_at), 32'd6);
    chk({name, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd6);
    chk({name, "_hidden"}, 32'(hidden_val), 32'(exp_h));
    chk({name, "_final"}, 32'(final_val), 32'(exp_f));
  endtask

  task automatic watch_no_done(input string name, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      cnt += int'(done);
    end
    chk(name, 32'(cnt), 32'd0);
  endtask

  initial begin
    int done_cnt, first_done, second_done;
    rst_n = 1'b0; zwr = 1'b0; start = 1'b0;
    set_in(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_final", 32'(final_val), 32'd0);
    rst_n = 1'b1;
    step();

    set_in(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd3, 8'd0);
    run_pass("basic", 100, 300);
    set_in(4'b0101, 8'd10, 8'd20, 8'd30, 8'd40, 8'd2, 8'd0);
    run_pass("mask", 40, 80);
    set_in(4'b0000, 8'd10, 8'd20, 8'd30, 8'd40, 8'd2, 8'd0);
    run_pass("zero_x", 0, 0);
    set_in(4'b1111, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd10);
`ifdef HIDDEN_FWD_BIAS_EN
    run_pass("max", 1023, 260865);
`else
    run_pass("max", 1020, 260100);
`endif

    // Input isolation: w0 changes at E2, a second start with new inputs at E3.
    set_in(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd3, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) w0 = 8'd200;
      if (i == 3) begin
        start = 1'b1;
        set_in(4'b0011, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0);
      end
      step();
      start = 1'b0;
      done_cnt += int'(done);
    end
    chk("isolate_done_count", 32'(done_cnt), 32'd1);
    chk("isolate_hidden", 32'(hidden_val), 32'd100);
    chk("isolate_final", 32'(final_val), 32'd300);

    // Start held high: accepts at every 7th edge.
    set_in(4'b0011, 8'd7, 8'd8, 8'd0, 8'd0, 8'd4, 8'd0);
    start = 1'b1;
    done_cnt = 0; first_done = -1; second_done = -1;
    for (int j = 0; j < 21; j++) begin
      step();
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = j;
        else if (second_done < 0) second_done = j;
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_cnt), 32'd3);
    chk("held_first_done", 32'(first_done), 32'd6);
    chk("held_period", 32'(second_done - first_done), 32'd7);
    chk("held_final", 32'(final_val), 32'd60);
    step();
    step();

    // Mid-pass clears at E3, via rst_i then via zero_weight_reset_i.
    for (int r = 0; r < 2; r++) begin
      set_in(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd3, 8'd0);
      run_pass("preclear", 100, 300);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      if (r == 0) rst_n = 1'b0;
      else zwr = 1'b1;
      step();
      chk("clear_busy", 32'(busy), 32'd0);
      chk("clear_hidden", 32'(hidden_val), 32'd0);
      chk("clear_final", 32'(final_val), 32'd0);
      rst_n = 1'b1; zwr = 1'b0;
      watch_no_done("clear_no_done", 10);
    end

    // Reset wins over a simultaneous start.
    rst_n = 1'b0; start = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0;
    step();
    chk("rst_start_busy", 32'(busy), 32'd0);
    watch_no_done("rst_start_no_done", 10);

    // Randomized traffic including occasional clears.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(3) == 0);
      rst_n = ($urandom_range(99) != 0);
      zwr   = ($urandom_range(99) == 0);
      set_in(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
